fp_byte_sequencer: RTL and testbench
====================================

# fp_byte_sequencer

Parametrised byte-serial operand/result sequencer for the floating-point ALU. Assembles WIDTH-bit operands from an 8-bit input bus, issues one operation to an external ALU core over a req/ack handshake with watchdog timeout, and streams the result back out byte by byte. Sits between the Tiny Tapeout pin wrapper and the ALU core, replacing the fixed 32-bit loader with a width-generic, unary-aware, abortable front end.

## Interface
- WIDTH, 32, operand/result width in bits; multiple of 8, range 16..64
- TIMEOUT, 255, max cycles core_req may wait for core_ack; range 1..65535
- UNARY_MASK, 8'b1100_0000, bit n set = opcode n takes operand A only

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_data  in  8  operand byte
- in_valid  in  1  byte strobe; in_data consumed on each cycle high in LOAD_A/LOAD_B
- op  in  3  opcode, sampled with start
- start  in  1  issue request, honoured only in READY
- rd  in  1  result byte consumed; advances unload pointer
- abort  in  1  synchronous return to IDLE from any state
- out_data  out  8  current result byte
- out_valid  out  1  out_data holds a valid result byte
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after final result byte read
- err  out  1  sticky timeout flag; cleared by next accepted in_valid in IDLE or by reset
- core_req  out  1  request to ALU core
- core_op  out  3  registered opcode
- core_a, core_b  out  WIDTH  registered operands (core_b zero for unary ops)
- core_ack  in  1  one-cycle acknowledge; core_result valid same cycle
- core_result  in  WIDTH  result word

## Operation
- States: IDLE, LOAD_A, LOAD_B, READY, ISSUE, UNLOAD.
- IDLE: in_valid -> byte 0 of A stored, go LOAD_A (byte count = 1); clears err.
- LOAD_A/LOAD_B: byte k written to bits [8k+7:8k] (little-endian); byte counter wraps to 0 after WIDTH/8 bytes. A complete -> LOAD_B. B complete -> READY. in_valid ignored in all other states.
- READY: start -> latch op to core_op; if UNARY_MASK[op] then core_b forced 0. Go ISSUE. Unary ops still require B loaded (B bytes discarded when unary); operand phase is opcode-agnostic because op arrives with start.
- ISSUE: core_req held high until core_ack. On ack: capture core_result, core_req low, go UNLOAD. Watchdog counts cycles in ISSUE; reaching TIMEOUT without ack -> err=1, core_req low, go IDLE.
- UNLOAD: out_valid=1, out_data = result byte[ptr], ptr starts 0. rd advances ptr; rd on last byte -> done pulse, go IDLE.
- abort: highest priority; any state -> IDLE, core_req low, counters 0, no done; core_ack arriving in IDLE ignored. err unaffected.
- Simultaneous core_ack and watchdog expiry in same cycle: ack wins, no err.

## Timing
- Reset: all outputs 0, state IDLE, counters 0, operand/result regs 0.
- Last B byte at cycle t -> READY at t+1; start at t (same cycle) ignored.
- start at t -> core_req high at t+1.
- core_ack at t -> core_req low and out_valid high at t+1, out_data = result byte 0.
- rd at t -> next byte on out_data at t+1; done high at t+1 after final rd, busy low same cycle.
- Minimum round trip WIDTH=32, ack in first req cycle: 8 load + 1 READY + 1 ISSUE + 4 unload cycles.

## Structure
- Package fp_seq_pkg: state enum, opcode width constant (3), opcode localparams shared with ALU core, default UNARY_MASK.
- Sub-module byte_shifter: WIDTH-generic byte-addressed register with write-enable/index, reused for operand A, B and result readout mux.

## Test plan
- WIDTH=32, load A=0x3F800000 (bytes 00,00,80,3F), B=0x40000000, op=0, stub core acks after 3 cycles with 0x40400000 -> core_a/core_b match, out bytes 00,00,40,40, one done pulse.
- Unary: op=7, load A=0xBF800000, any B -> core_b=0, result bytes read back in order.
- Timeout: TIMEOUT=4, core never acks -> core_req high exactly 4 cycles, err=1, IDLE; next in_valid clears err.
- abort after 2 A bytes and again during ISSUE -> IDLE next cycle, core_req low, late core_ack ignored, no done.
- WIDTH=16: A=0x3C00, B=0x4000, result 0x4200 -> 2 bytes per operand, out 00,42.
- Reset asserted mid-UNLOAD -> all outputs 0 immediately, fresh transaction completes correctly.

Source files
------------

// File: rtl/fp_byte_sequencer_pkg.sv
// Shared definitions for the byte-serial FP ALU sequencer: FSM states,
// opcode encodings agreed with the ALU core, default unary-opcode mask.
package fp_seq_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_READY,
    S_ISSUE,
    S_UNLOAD
  } seq_state_t;

  localparam logic [OP_W-1:0] OP_ADD = 3'd0;
  localparam logic [OP_W-1:0] OP_SUB = 3'd1;
  localparam logic [OP_W-1:0] OP_MUL = 3'd2;
  localparam logic [OP_W-1:0] OP_DIV = 3'd3;
  localparam logic [OP_W-1:0] OP_MIN = 3'd4;
  localparam logic [OP_W-1:0] OP_MAX = 3'd5;
  localparam logic [OP_W-1:0] OP_NEG = 3'd6;
  localparam logic [OP_W-1:0] OP_ABS = 3'd7;

  // Opcodes 6 and 7 (NEG, ABS) consume operand A only.
  localparam logic [7:0] UNARY_MASK_DEF = 8'b1100_0000;

endpackage

// File: rtl/fp_byte_sequencer_byte_shifter.sv
// WIDTH-bit register with byte-indexed write and byte-indexed read,
// plus whole-word load and clear; used for operands and result readout.
module byte_shifter #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned IDX_W = $clog2(WIDTH / 8)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] ldata,
  input  logic             we,
  input  logic [IDX_W-1:0] idx,
  input  logic [7:0]       wdata,
  output logic [WIDTH-1:0] q,
  output logic [7:0]       rdata
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (load) begin
      q <= ldata;
    end else if (we) begin
      q[{idx, 3'b000} +: 8] <= wdata;
    end
  end

  assign rdata = q[{idx, 3'b000} +: 8];

endmodule

// File: rtl/fp_byte_sequencer.sv
// Byte-serial operand loader / result unloader in front of the FP ALU core,
// with req/ack handshake, watchdog timeout and synchronous abort.
module fp_byte_sequencer
  import fp_seq_pkg::*;
#(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned TIMEOUT    = 255,
  parameter logic [7:0]  UNARY_MASK = UNARY_MASK_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic [OP_W-1:0]  op,
  input  logic             start,
  input  logic             rd,
  input  logic             abort,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             core_req,
  output logic [OP_W-1:0]  core_op,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_ack,
  input  logic [WIDTH-1:0] core_result
);

  localparam int unsigned NB    = WIDTH / 8;
  localparam int unsigned IDX_W = $clog2(NB);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);
  localparam logic [15:0]      WD_LAST  = 16'(TIMEOUT - 1);

  seq_state_t       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [15:0]      wd_q, wd_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [OP_W-1:0]  op_q;
  logic             a_we, b_we, b_clr, r_load, op_we;
  logic [7:0]       r_byte;
  logic [7:0]       a_byte_unused, b_byte_unused;
  logic [WIDTH-1:0] res_word_unused;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      wd_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      wd_q    <= wd_d;
      err_q   <= err_d;
      done_q  <= done_d;
      if (op_we) op_q <= op;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    wd_d    = wd_q;
    err_d   = err_q;
    done_d  = 1'b0;
    a_we    = 1'b0;
    b_we    = 1'b0;
    b_clr   = 1'b0;
    r_load  = 1'b0;
    op_we   = 1'b0;
    if (abort) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ptr_d   = '0;
      wd_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: if (in_valid) begin
          a_we    = 1'b1;
          cnt_d   = IDX_W'(1);
          err_d   = 1'b0;
          state_d = S_LOAD_A;
        end
        S_LOAD_A: if (in_valid) begin
          a_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_LOAD_B: if (in_valid) begin
          b_we = 1'b1;
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = S_READY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        // Unary ops zero B in place so core_b needs no separate register.
        S_READY: if (start) begin
          op_we   = 1'b1;
          b_clr   = UNARY_MASK[op];
          wd_d    = '0;
          state_d = S_ISSUE;
        end
        S_ISSUE: begin
          if (core_ack) begin
            r_load  = 1'b1;
            ptr_d   = '0;
            wd_d    = '0;
            state_d = S_UNLOAD;
          end else if (wd_q == WD_LAST) begin
            err_d   = 1'b1;
            wd_d    = '0;
            state_d = S_IDLE;
          end else begin
            wd_d = wd_q + 1'b1;
          end
        end
        S_UNLOAD: if (rd) begin
          if (ptr_q == LAST_IDX) begin
            ptr_d   = '0;
            done_d  = 1'b1;
            state_d = S_IDLE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  byte_shifter #(.WIDTH(WIDTH)) u_opa (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(1'b0), .ldata('0),
    .we(a_we), .idx(cnt_q), .wdata(in_data), .q(core_a), .rdata(a_byte_unused)
  );

  byte_shifter #(.WIDTH(WIDTH)) u_opb (
    .clk(clk), .rst_n(rst_n), .clr(b_clr), .load(1'b0), .ldata('0),
    .we(b_we), .idx(cnt_q), .wdata(in_data), .q(core_b), .rdata(b_byte_unused)
  );

  byte_shifter #(.WIDTH(WIDTH)) u_res (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .load(r_load), .ldata(core_result),
    .we(1'b0), .idx(ptr_q), .wdata(8'h00), .q(res_word_unused), .rdata(r_byte)
  );

  assign core_req  = (state_q == S_ISSUE);
  assign out_valid = (state_q == S_UNLOAD);
  assign out_data  = out_valid ? r_byte : 8'h00;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign core_op   = op_q;

endmodule

// File: tb/tb_fp_byte_sequencer.sv
// Directed plus randomized transactions on a 32-bit (TIMEOUT=4) and a 16-bit
// sequencer, checked against word-level expectations computed here.
module tb_fp_byte_sequencer;

  localparam logic [7:0] UM = 8'b1100_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, in_valid, sel16, start, rd, abort, core_ack;
  logic [7:0]  in_data;
  logic [2:0]  op;
  logic [31:0] core_result;

  logic [7:0]  o32_out_data, o16_out_data;
  logic        o32_out_valid, o32_busy, o32_done, o32_err, o32_core_req;
  logic        o16_out_valid, o16_busy, o16_done, o16_err, o16_core_req;
  logic [2:0]  o32_core_op, o16_core_op;
  logic [31:0] o32_core_a, o32_core_b;
  logic [15:0] o16_core_a, o16_core_b;

  fp_byte_sequencer #(.WIDTH(32), .TIMEOUT(4), .UNARY_MASK(UM)) u32 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid & ~sel16),
    .op(op), .start(start), .rd(rd), .abort(abort),
    .out_data(o32_out_data), .out_valid(o32_out_valid), .busy(o32_busy),
    .done(o32_done), .err(o32_err), .core_req(o32_core_req), .core_op(o32_core_op),
    .core_a(o32_core_a), .core_b(o32_core_b), .core_ack(core_ack),
    .core_result(core_result)
  );

  fp_byte_sequencer #(.WIDTH(16), .TIMEOUT(20), .UNARY_MASK(UM)) u16 (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid & sel16),
    .op(op), .start(start), .rd(rd), .abort(abort),
    .out_data(o16_out_data), .out_valid(o16_out_valid), .busy(o16_busy),
    .done(o16_done), .err(o16_err), .core_req(o16_core_req), .core_op(o16_core_op),
    .core_a(o16_core_a), .core_b(o16_core_b), .core_ack(core_ack),
    .core_result(core_result[15:0])
  );

  logic [7:0]  out_data_o;
  logic        out_valid_o, busy_o, done_o, err_o, core_req_o;
  logic [2:0]  core_op_o;
  logic [31:0] core_a_o, core_b_o;

  always_comb begin
    if (sel16) begin
      out_data_o = o16_out_data;  out_valid_o = o16_out_valid; busy_o = o16_busy;
      done_o = o16_done; err_o = o16_err; core_req_o = o16_core_req;
      core_op_o = o16_core_op; core_a_o = {16'h0, o16_core_a}; core_b_o = {16'h0, o16_core_b};
    end else begin
      out_data_o = o32_out_data;  out_valid_o = o32_out_valid; busy_o = o32_busy;
      done_o = o32_done; err_o = o32_err; core_req_o = o32_core_req;
      core_op_o = o32_core_op; core_a_o = o32_core_a; core_b_o = o32_core_b;
    end
  end

  int total = 0;
  int bad   = 0;
  bit err_m [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on the selected DUT. d = index of the req cycle in which
  // ack is given; nrd < bytes stops after nrd reads, leaving the DUT unloading.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] opc,
                         input int d, input logic [31:0] res, input int nrd,
                         input bit early_start);
    int nb, tmo, i;
    logic [31:0] wmask, ea, eb, er;
    nb    = sel16 ? 2 : 4;
    tmo   = sel16 ? 20 : 4;
    wmask = sel16 ? 32'h0000_FFFF : 32'hFFFF_FFFF;
    ea    = a & wmask;
    eb    = UM[opc] ? 32'h0 : (b & wmask);
    er    = res & wmask;
    chk("idle_busy", busy_o, 0);
    chk("err_before_load", err_o, err_m[sel16]);
    for (int k = 0; k < 2 * nb; k++) begin
      in_valid = 1'b1;
      in_data  = (k < nb) ? 8'(a >> (8 * k)) : 8'(b >> (8 * (k - nb)));
      if (k == 2 * nb - 1 && early_start) begin start = 1'b1; op = opc; end
      @(negedge clk);
      if (k == 0) begin
        err_m[sel16] = 1'b0;
        chk("err_cleared", err_o, 0);
      end
      chk("load_busy", busy_o, 1);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    if (early_start) begin
      @(negedge clk);
      chk("early_start_ignored", core_req_o, 0);
    end
    start = 1'b1; op = opc;
    @(negedge clk);
    start = 1'b0; op = 3'($urandom);
    chk("core_a", core_a_o, ea);
    chk("core_b", core_b_o, eb);
    chk("core_op", core_op_o, opc);
    for (i = 0; i < tmo && i <= d; i++) begin
      chk("req_high", core_req_o, 1);
      if (i == d) begin core_ack = 1'b1; core_result = res; end
      @(negedge clk);
      core_ack = 1'b0; core_result = $urandom;
    end
    if (d >= tmo) begin
      chk("tmo_req_low", core_req_o, 0);
      chk("tmo_err", err_o, 1);
      chk("tmo_idle", busy_o, 0);
      err_m[sel16] = 1'b1;
      return;
    end
    chk("ack_req_low", core_req_o, 0);
    for (int k = 0; k < nb; k++) begin
      chk("out_valid", out_valid_o, 1);
      chk("out_byte", out_data_o, 8'(er >> (8 * k)));
      chk("no_early_done", done_o, 0);
      if (k == nrd) return;
      rd = 1'b1;
      @(negedge clk);
      rd = 1'b0;
    end
    chk("done_pulse", done_o, 1);
    chk("done_not_busy", busy_o, 0);
    chk("done_out_invalid", out_valid_o, 0);
    @(negedge clk);
    chk("done_one_cycle", done_o, 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; sel16 = 1'b0; start = 1'b0; rd = 1'b0;
    abort = 1'b0; core_ack = 1'b0; in_data = '0; op = '0; core_result = '0;
    err_m[0] = 1'b0; err_m[1] = 1'b0;
    #12;
    chk("rst32_outs", {o32_out_data, o32_out_valid, o32_busy, o32_done, o32_err,
                       o32_core_req, o32_core_op}, 0);
    chk("rst32_ops", {o32_core_a, o32_core_b}, 0);
    chk("rst16_outs", {o16_out_data, o16_out_valid, o16_busy, o16_done, o16_err,
                       o16_core_req, o16_core_op, o16_core_a, o16_core_b}, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // Binary op, ack coincides with the last watchdog cycle (ack must win)
    run_txn(32'h3F80_0000, 32'h4000_0000, 3'd0, 3, 32'h4040_0000, 99, 1'b1);
    // Unary op: core_b must read zero
    run_txn(32'hBF80_0000, $urandom, 3'd7, 1, $urandom, 99, 1'b0);
    // Never acked: watchdog expiry, then err clears on the next first byte
    run_txn($urandom, $urandom, 3'd2, 50, $urandom, 99, 1'b0);
    run_txn($urandom, $urandom, 3'd1, 0, $urandom, 99, 1'b0);

    // Abort after two A bytes, then abort during ISSUE with a late ack
    for (int k = 0; k < 2; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom); @(negedge clk);
    end
    in_valid = 1'b0; abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_load_idle", busy_o, 0);
    for (int k = 0; k < 8; k++) begin
      in_valid = 1'b1; in_data = 8'($urandom); @(negedge clk);
    end
    in_valid = 1'b0; start = 1'b1; op = 3'd3; @(negedge clk); start = 1'b0;
    chk("pre_abort_req", core_req_o, 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    chk("abort_issue_req", core_req_o, 0);
    chk("abort_issue_idle", busy_o, 0);
    core_ack = 1'b1; core_result = $urandom; @(negedge clk); core_ack = 1'b0;
    chk("late_ack_no_unload", out_valid_o, 0);
    chk("late_ack_no_done", done_o, 0);
    chk("late_ack_idle", busy_o, 0);
    run_txn(32'h1234_5678, 32'h9ABC_DEF0, 3'd4, 2, 32'hCAFE_F00D, 99, 1'b0);

    for (int n = 0; n < 8; n++)
      run_txn($urandom, $urandom, 3'($urandom), int'($urandom_range(0, 5)), $urandom, 99, 1'b0);

    sel16 = 1'b1;
    run_txn(32'h3C00, 32'h4000, 3'd0, 2, 32'h4200, 99, 1'b0);
    for (int n = 0; n < 3; n++)
      run_txn($urandom, $urandom, 3'($urandom), int'($urandom_range(0, 3)), $urandom, 99, 1'b0);

    // Reset while unloading, then a clean transaction
    sel16 = 1'b0;
    run_txn($urandom, $urandom, 3'd1, 0, $urandom, 1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("midrst_outs", {out_data_o, out_valid_o, busy_o, done_o, err_o, core_req_o, core_op_o}, 0);
    chk("midrst_ops", {core_a_o, core_b_o}, 0);
    err_m[0] = 1'b0; err_m[1] = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    run_txn(32'hDEAD_BEEF, 32'h0BAD_F00D, 3'd6, 1, 32'h5555_AAAA, 99, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
